// File: rtl/crc_ctrl_pkg.sv
// Shared types and default geometry for the CRC frame sequencer.
package crc_ctrl_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_CRC_W   = 8;
    localparam int unsigned DEF_LEN_W   = 4;
    localparam int unsigned DEF_TIMEOUT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StShift,
        StWaitV,
        StCapture,
        StAbort
    } ctrl_state_e;

endpackage

// File: rtl/crc_byte_serializer.sv
// Byte prefetch register plus LSB-first shift register feeding the serial CRC engine.
module crc_byte_serializer
    import crc_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              frame_start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              fill_en,
    input  logic              load_req,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pf_full,
    output logic              bit_out,
    output logic              last_bit,
    output logic              last_byte,
    output logic              underrun
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [LEN_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [DATA_W-1:0] pf_q, pf_d;
    logic              pf_full_q, pf_full_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              ready_q, ready_d;

    logic accept;
    logic more;
    logic boundary;
    logic load;

    assign accept     = ready_q & byte_valid;
    assign more       = ld_cnt_q < len_q;
    assign last_bit   = bit_cnt_q == CNT_W'(DATA_W - 1);
    assign boundary   = shift_en & last_bit;
    assign load       = pf_full_q & (load_req | (boundary & more));
    assign underrun   = boundary & more & ~pf_full_q;
    assign last_byte  = ~more;
    assign pf_full    = pf_full_q;
    assign byte_ready = ready_q;
    // Right shift with zero fill: bit 0 is the current engine bit and drains to 0 after a frame.
    assign bit_out    = shift_q[0];

    always_comb begin
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        ld_cnt_d  = ld_cnt_q;
        pf_d      = pf_q;
        pf_full_d = pf_full_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (frame_start) begin
            len_d     = frame_len;
            acc_cnt_d = '0;
            ld_cnt_d  = '0;
            pf_full_d = 1'b0;
            shift_d   = '0;
            bit_cnt_d = '0;
        end else begin
            if (load) begin
                shift_d   = pf_q;
                bit_cnt_d = '0;
                ld_cnt_d  = ld_cnt_q + LEN_W'(1);
                pf_full_d = 1'b0;
            end else if (shift_en) begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
            end
            if (accept) begin
                pf_d      = byte_data;
                pf_full_d = 1'b1;
                acc_cnt_d = acc_cnt_q + LEN_W'(1);
            end
        end
        // Registered ready is computed from next-state so it is never stale by a cycle.
        ready_d = fill_en & ~pf_full_d & (acc_cnt_d < len_d);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            len_q     <= '0;
            acc_cnt_q <= '0;
            ld_cnt_q  <= '0;
            pf_q      <= '0;
            pf_full_q <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
            pf_q      <= pf_d;
            pf_full_q <= pf_full_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the serial CRC engine: clear, serialize bytes with Active held,
// then collect the serial CRC into a parallel result.
module crc_frame_ctrl
    import crc_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CRC_W   = DEF_CRC_W,
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              eng_data,
    output logic              eng_active,
    output logic              eng_clr,
    input  logic              eng_crc,
    input  logic              eng_valid,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_done,
    output logic              busy,
    output logic              err
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CAP_W = (CRC_W > 1) ? $clog2(CRC_W) : 1;

    ctrl_state_e state_q, state_d;

    logic [TO_W-1:0]  to_q, to_d;
    logic [CAP_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [CRC_W-1:0] cap_q, cap_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic             crc_done_q, crc_done_d;
    logic             err_q, err_d;
    logic             eng_active_q, eng_active_d;
    logic             eng_clr_q, eng_clr_d;
    logic             busy_q, busy_d;

    logic             frame_start;
    logic             fill_en;
    logic             load_req;
    logic             shift_en;
    logic             pf_full;
    logic             ser_bit;
    logic             last_bit;
    logic             last_byte;
    logic             underrun;
    logic [CRC_W:0]   cap_ext;
    logic [CRC_W-1:0] cap_shift;

    // New bits enter at the MSB so the first received bit ends up in bit 0.
    assign cap_ext   = {eng_crc, cap_q};
    assign cap_shift = cap_ext[CRC_W:1];

    crc_byte_serializer #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_serializer (
        .clk         (clk),
        .RST         (RST),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .fill_en     (fill_en),
        .load_req    (load_req),
        .shift_en    (shift_en),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .pf_full     (pf_full),
        .bit_out     (ser_bit),
        .last_bit    (last_bit),
        .last_byte   (last_byte),
        .underrun    (underrun)
    );

    always_comb begin
        state_d     = state_q;
        to_d        = to_q;
        cap_cnt_d   = cap_cnt_q;
        cap_d       = cap_q;
        crc_out_d   = crc_out_q;
        crc_done_d  = 1'b0;
        err_d       = 1'b0;
        frame_start = 1'b0;
        load_req    = 1'b0;
        shift_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && (frame_len != '0)) begin
                    frame_start = 1'b1;
                    state_d     = StClear;
                end
            end
            StClear: state_d = StLoad;
            StLoad: begin
                load_req = 1'b1;
                if (pf_full) state_d = StShift;
            end
            StShift: begin
                shift_en = 1'b1;
                if (underrun) begin
                    err_d   = 1'b1;
                    state_d = StAbort;
                end else if (last_bit && last_byte) begin
                    to_d      = '0;
                    cap_cnt_d = '0;
                    state_d   = StWaitV;
                end
            end
            StWaitV, StCapture: begin
                if (eng_valid) begin
                    cap_d = cap_shift;
                    to_d  = '0;
                    if (cap_cnt_q == CAP_W'(CRC_W - 1)) begin
                        crc_out_d  = cap_shift;
                        crc_done_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        cap_cnt_d = cap_cnt_q + CAP_W'(1);
                        state_d   = StCapture;
                    end
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StAbort;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        eng_active_d = state_d == StShift;
        eng_clr_d    = state_d inside {StClear, StAbort};
        busy_d       = state_d != StIdle;
        fill_en      = state_d inside {StClear, StLoad, StShift};
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            to_q         <= '0;
            cap_cnt_q    <= '0;
            cap_q        <= '0;
            crc_out_q    <= '0;
            crc_done_q   <= 1'b0;
            err_q        <= 1'b0;
            eng_active_q <= 1'b0;
            eng_clr_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_q         <= to_d;
            cap_cnt_q    <= cap_cnt_d;
            cap_q        <= cap_d;
            crc_out_q    <= crc_out_d;
            crc_done_q   <= crc_done_d;
            err_q        <= err_d;
            eng_active_q <= eng_active_d;
            eng_clr_q    <= eng_clr_d;
            busy_q       <= busy_d;
        end
    end

    assign eng_data   = ser_bit;
    assign eng_active = eng_active_q;
    assign eng_clr    = eng_clr_q;
    assign crc_out    = crc_out_q;
    assign crc_done   = crc_done_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: doc/crc_frame_ctrl.md
Name: crc_frame_ctrl

Overview:
Sequencer for the serial CRC engine (DATA/Active in, CRC/Valid out). It accepts a frame of parallel bytes over a valid/ready handshake and clears the engine before each frame. It then serializes the bytes LSB-first into the engine with Active held continuously. Once Active drops, it collects the engine's serial CRC into a parallel result. It sits between the byte-oriented packet path and the CRC engine; the top level ORs eng_clr with the system reset into the engine's RST.

Parameters:
DATA_W, 8, bits per byte shifted into the engine
CRC_W, 8, CRC width returned serially by the engine
LEN_W, 4, width of frame_len (max frame 2^LEN_W-1 bytes)
TIMEOUT, 16, cycles to wait for eng_valid after Active falls

Ports:
clk  in  1  system clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
start  in  1  frame request, sampled only in IDLE
frame_len  in  LEN_W  byte count, latched on accepted start
byte_data  in  DATA_W  frame byte
byte_valid  in  1  byte_data valid
byte_ready  out  1  prefetch register empty; transfer on valid&ready
eng_data  out  1  serial bit to engine DATA
eng_active  out  1  engine Active
eng_clr  out  1  one-cycle engine clear pulse
eng_crc  in  1  engine serial CRC bit
eng_valid  in  1  engine CRC bit valid
crc_out  out  CRC_W  captured CRC, LSB = first bit received
crc_done  out  1  one-cycle pulse, crc_out valid
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse on underrun or timeout

Behaviour:
- Reset (async): state=IDLE. All outputs 0, crc_out=0, counters and prefetch register cleared.
- Reset mid-frame: immediate return to IDLE. Partial bytes and CRC are discarded, and no crc_done or err pulse is issued.
- Outputs are registered. eng_data/eng_active change only after rising edges, and the engine samples them on the next edge.
- IDLE: start=1 with frame_len!=0 latches the length and goes to CLEAR. start with frame_len=0 is ignored (busy stays 0).
- CLEAR: eng_clr=1 for exactly 1 cycle, then LOAD. byte_ready may assert from CLEAR onward.
- LOAD: waits for the first byte in the prefetch register. Goes to SHIFT the cycle after the byte is present.
- SHIFT: eng_active=1, eng_data=shift_reg[bit_cnt], bit_cnt 0..DATA_W-1.
  - On bit DATA_W-1 with bytes remaining: the prefetch byte moves into the shift register with no gap cycle, and Active stays high.
  - If the prefetch register is empty at that point: underrun. Drop Active, pulse err, go to ABORT.
- Prefetch handshake: byte_ready = (prefetch empty) & (bytes accepted < frame_len). Consume and refill in the same cycle is allowed. Bytes beyond frame_len are never accepted.
- Last bit of last byte: next cycle eng_active=0, state=WAIT_V, timeout counter cleared.
- WAIT_V: goes to CAPTURE on the first cycle eng_valid=1, sampling eng_crc into crc bit 0 that same cycle. If eng_valid is not seen within TIMEOUT cycles: pulse err, go to ABORT.
- CAPTURE: each cycle with eng_valid=1 samples the next bit. eng_valid low mid-capture stalls the capture, and the same TIMEOUT applies. After CRC_W bits, crc_out is updated and crc_done pulses for 1 cycle on the next cycle, then IDLE.
- ABORT: eng_clr=1 for 1 cycle to flush the engine, then IDLE. crc_out keeps its previous value.
- crc_out holds its value until the next successful frame.
- Latency, N-byte frame with bytes always available: start→first Active = 3 cycles; Active high for N·DATA_W consecutive cycles.

Decomposition:
- Package crc_ctrl_pkg holds:
  - state enum (IDLE, CLEAR, LOAD, SHIFT, WAIT_V, CAPTURE, ABORT)
  - default widths (DATA_W, CRC_W) and TIMEOUT
- One natural sub-module: crc_byte_serializer. It holds the prefetch register, shift register and bit counter, and exposes bit, last_bit and underrun.
- The FSM, capture shift register and timeout stay in the top.

Test Plan:
- Single-byte frame: frame_len=1, byte 0xA5, engine stub returns Valid for 8 cycles with bits of 0x3C.
  - eng_data = 1,0,1,0,0,1,0,1 on 8 consecutive Active cycles.
  - eng_clr pulses once before Active.
  - crc_out=0x3C with one crc_done pulse; busy falls the same cycle.
- Three-byte back-to-back frame: bytes 0x01, 0xFF, 0x80 with byte_valid always 1.
  - Active high for exactly 24 contiguous cycles.
  - Bit stream matches LSB-first order.
  - byte_ready never accepts a 4th byte.
- Underrun: frame_len=2, second byte withheld.
  - Active falls after 8 bits, err pulses once, eng_clr pulses once.
  - No crc_done; crc_out unchanged; returns to IDLE.
- Timeout and stall:
  - Stub never raises eng_valid → err pulse TIMEOUT(16) cycles after Active falls.
  - Stub drops eng_valid for 3 cycles mid-CRC → capture stalls, and still yields 0x3C.
- Reset and length corner cases:
  - RST asserted during SHIFT → all outputs 0 asynchronously.
  - A new frame of 0x00 then completes normally.
  - start with frame_len=0 → busy stays 0, no eng_clr.
